// File: rtl/lif_pkg.sv
// Shared constants and state encoding for the leaky integrate-and-fire neuron.
package lif_pkg;

    // Neuron control states
    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_t;

    // Default parameter values
    localparam int LIF_WIDTH          = 8;
    localparam int LIF_CUR_SHIFT      = 1;
    localparam int LIF_LEAK_SHIFT     = 3;
    localparam int LIF_REFRACT_CYCLES = 4;
    localparam int LIF_RESET_MODE     = 0;

    // Width of a down-counter able to hold n (at least one bit)
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lif_sat_integrate.sv
// Combinational leak-and-integrate step: (V - V>>LEAK) + (I>>CUR), saturated to WIDTH bits.
module lif_sat_integrate #(
    parameter int WIDTH      = 8,
    parameter int CUR_SHIFT  = 1,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] scaled;
    logic [WIDTH:0]   wide;

    // Leak never underflows since V>>LEAK <= V; the add gets one extra bit for carry
    always_comb begin
        leaked = v - (v >> LEAK_SHIFT);
        scaled = cur >> CUR_SHIFT;
        wide   = {1'b0, leaked} + {1'b0, scaled};
        sum    = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
    end

endmodule

// File: rtl/lif_neuron_param.sv
// Parametrised leaky integrate-and-fire neuron with refractory period and spike counter.
module lif_neuron_param
    import lif_pkg::*;
#(
    parameter int WIDTH          = LIF_WIDTH,
    parameter int CUR_SHIFT      = LIF_CUR_SHIFT,
    parameter int LEAK_SHIFT     = LIF_LEAK_SHIFT,
    parameter int REFRACT_CYCLES = LIF_REFRACT_CYCLES,
    parameter int RESET_MODE     = LIF_RESET_MODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] synaptic_current,
    input  logic [WIDTH-1:0] threshold,
    output logic             spike,
    output logic [WIDTH-1:0] membrane_potential,
    output logic             refractory,
    output logic [15:0]      spike_count
);

    localparam int CNT_W = cnt_width(REFRACT_CYCLES);

    lif_state_t       state_reg, state_next;
    logic [CNT_W-1:0] rcnt_reg, rcnt_next;
    logic [WIDTH-1:0] v_reg, v_next;
    logic             spike_reg, spike_next;
    logic [15:0]      count_reg, count_next;
    logic [WIDTH-1:0] sum;
    logic             fire;

    lif_sat_integrate #(
        .WIDTH      (WIDTH),
        .CUR_SHIFT  (CUR_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_integrate (
        .v   (v_reg),
        .cur (synaptic_current),
        .sum (sum)
    );

    assign fire = (sum >= threshold);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INTEGRATE;
            rcnt_reg  <= '0;
            v_reg     <= '0;
            spike_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
            v_reg     <= v_next;
            spike_reg <= spike_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic: integrate/fire or count down the refractory period; everything holds when en=0
    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        v_next     = v_reg;
        spike_next = 1'b0;
        count_next = count_reg;
        if (en) begin
            case (state_reg)
                ST_INTEGRATE: begin
                    if (fire) begin
                        spike_next = 1'b1;
                        count_next = count_reg + 16'd1;
                        v_next     = (RESET_MODE == 1) ? (sum - threshold) : '0;
                        if (REFRACT_CYCLES > 0) begin
                            state_next = ST_REFRACTORY;
                            rcnt_next  = CNT_W'(REFRACT_CYCLES);
                        end
                    end else begin
                        v_next = sum;
                    end
                end
                ST_REFRACTORY: begin
                    rcnt_next = rcnt_reg - CNT_W'(1);
                    if (rcnt_reg == CNT_W'(1)) begin
                        state_next = ST_INTEGRATE;
                    end
                end
                default: state_next = ST_INTEGRATE;
            endcase
        end
    end

    assign spike              = spike_reg;
    assign membrane_potential = v_reg;
    assign refractory         = (state_reg == ST_REFRACTORY);
    assign spike_count        = count_reg;

endmodule

// File: tb/tb_lif_neuron_param.sv
// Self-checking bench: two neuron instances (default, and subtract-reset with no refractory)
// compared against a behavioural model built from the firing rules.
module tb_lif_neuron_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  cur = '0;
    logic [7:0]  thr = '0;

    logic        a_spike, b_spike, a_refr, b_refr;
    logic [7:0]  a_v, b_v;
    logic [15:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = instance a, index 1 = instance b
    int p_rm [2] = '{0, 1};
    int p_rc [2] = '{4, 0};
    int m_v [2];
    int m_cnt [2];
    int m_rleft [2];
    bit m_refr [2];
    bit m_spike [2];

    lif_neuron_param dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .synaptic_current(cur), .threshold(thr),
        .spike(a_spike), .membrane_potential(a_v), .refractory(a_refr), .spike_count(a_cnt)
    );

    lif_neuron_param #(.RESET_MODE(1), .REFRACT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .synaptic_current(cur), .threshold(thr),
        .spike(b_spike), .membrane_potential(b_v), .refractory(b_refr), .spike_count(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_cnt[k] = 0; m_rleft[k] = 0; m_refr[k] = 0; m_spike[k] = 0;
        end
    endtask

    task automatic model_step(input bit e, input int i, input int t);
        int s;
        for (int k = 0; k < 2; k++) begin
            if (!e) begin
                m_spike[k] = 0;
            end else if (m_refr[k]) begin
                m_spike[k] = 0;
                m_rleft[k] = m_rleft[k] - 1;
                if (m_rleft[k] == 0) m_refr[k] = 0;
            end else begin
                s = m_v[k] - m_v[k] / 8 + i / 2;
                if (s > 255) s = 255;
                if (s >= t) begin
                    m_spike[k] = 1;
                    m_v[k] = (p_rm[k] == 1) ? s - t : 0;
                    m_cnt[k] = (m_cnt[k] + 1) % 65536;
                    if (p_rc[k] > 0) begin
                        m_refr[k] = 1;
                        m_rleft[k] = p_rc[k];
                    end
                end else begin
                    m_spike[k] = 0;
                    m_v[k] = s;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge
    task automatic cycle(input bit e, input int i, input int t);
        en = e; cur = 8'(i); thr = 8'(t);
        @(posedge clk);
        model_step(e, i, t);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        #12;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_spike, a_refr, a_v, a_cnt} !== 26'd0) begin
            errors++; $display("FAIL reset_a: got spike=%0b refr=%0b v=%0d cnt=%0d, want all 0", a_spike, a_refr, a_v, a_cnt);
        end
        checks++;
        if ({b_spike, b_refr, b_v, b_cnt} !== 26'd0) begin
            errors++; $display("FAIL reset_b: got spike=%0b refr=%0b v=%0d cnt=%0d, want all 0", b_spike, b_refr, b_v, b_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_integrate_fire();
        int exp_v [7] = '{20, 38, 54, 68, 80, 90, 99};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            cycle(1'b1, 40, 100);
            checks++;
            if (a_v !== 8'(exp_v[n]) || a_spike !== 1'b0) begin
                errors++; $display("FAIL integrate_v[%0d]: got v=%0d spike=%0b, want v=%0d spike=0", n, a_v, a_spike, exp_v[n]);
            end
        end
        cycle(1'b1, 40, 100);
        checks++;
        if (a_spike !== 1'b1 || a_v !== 8'd0 || a_cnt !== 16'd1 || a_refr !== 1'b1) begin
            errors++; $display("FAIL fire_a: got spike=%0b v=%0d cnt=%0d refr=%0b, want 1 0 1 1", a_spike, a_v, a_cnt, a_refr);
        end
        checks++;
        if (b_spike !== 1'b1 || b_v !== 8'd7 || b_cnt !== 16'd1 || b_refr !== 1'b0) begin
            errors++; $display("FAIL fire_b_subtract: got spike=%0b v=%0d cnt=%0d refr=%0b, want 1 7 1 0", b_spike, b_v, b_cnt, b_refr);
        end
        $display("test_integrate_fire done");
    endtask

    // Continues from the spike above
    task automatic test_refractory();
        int exp_r [5] = '{1, 1, 1, 0, 0};
        int exp_v [5] = '{0, 0, 0, 0, 20};
        for (int n = 0; n < 5; n++) begin
            cycle(1'b1, 40, 100);
            checks++;
            if (a_refr !== 1'(exp_r[n]) || a_v !== 8'(exp_v[n]) || a_spike !== 1'b0) begin
                errors++; $display("FAIL refractory[%0d]: got refr=%0b v=%0d spike=%0b, want refr=%0d v=%0d spike=0", n, a_refr, a_v, a_spike, exp_r[n], exp_v[n]);
            end
            checks++;
            if (b_v !== 8'(m_v[1]) || b_spike !== m_spike[1] || b_refr !== 1'b0) begin
                errors++; $display("FAIL refractory_b[%0d]: got v=%0d spike=%0b refr=%0b, want v=%0d spike=%0b refr=0", n, b_v, b_spike, b_refr, m_v[1], m_spike[1]);
            end
        end
        $display("test_refractory done");
    endtask

    task automatic test_enable_hold();
        do_reset();
        for (int n = 0; n < 3; n++) cycle(1'b1, 40, 100);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 200, 0);
            checks++;
            if (a_v !== 8'd54 || a_spike !== 1'b0 || a_cnt !== 16'd0 || b_v !== 8'd54 || b_spike !== 1'b0) begin
                errors++; $display("FAIL en_hold[%0d]: got a_v=%0d a_spike=%0b a_cnt=%0d b_v=%0d b_spike=%0b, want 54 0 0 54 0", n, a_v, a_spike, a_cnt, b_v, b_spike);
            end
        end
        cycle(1'b1, 40, 100);
        checks++;
        if (a_v !== 8'd68) begin
            errors++; $display("FAIL en_resume: got v=%0d, want 68", a_v);
        end
        $display("test_enable_hold done");
    endtask

    task automatic test_reset_mid_refractory();
        do_reset();
        for (int n = 0; n < 10; n++) cycle(1'b1, 40, 100);
        checks++;
        if (a_refr !== 1'b1) begin
            errors++; $display("FAIL pre_async_refr: got refr=%0b, want 1", a_refr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_spike, a_refr, a_v, a_cnt} !== 26'd0 || {b_spike, b_v, b_cnt} !== 25'd0) begin
            errors++; $display("FAIL async_reset: got a refr=%0b v=%0d cnt=%0d b v=%0d cnt=%0d, want all 0", a_refr, a_v, a_cnt, b_v, b_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 40, 100);
        checks++;
        if (a_v !== 8'd20 || a_refr !== 1'b0) begin
            errors++; $display("FAIL post_reset_integrate: got v=%0d refr=%0b, want 20 0", a_v, a_refr);
        end
        $display("test_reset_mid_refractory done");
    endtask

    task automatic test_saturation();
        int exp_v [2] = '{127, 239};
        do_reset();
        for (int n = 0; n < 2; n++) begin
            cycle(1'b1, 255, 255);
            checks++;
            if (a_v !== 8'(exp_v[n]) || a_spike !== 1'b0) begin
                errors++; $display("FAIL sat_v[%0d]: got v=%0d spike=%0b, want v=%0d spike=0", n, a_v, a_spike, exp_v[n]);
            end
        end
        cycle(1'b1, 255, 255);
        checks++;
        if (a_spike !== 1'b1 || a_v !== 8'd0 || b_spike !== 1'b1 || b_v !== 8'd0) begin
            errors++; $display("FAIL sat_fire: got a spike=%0b v=%0d b spike=%0b v=%0d, want 1 0 1 0", a_spike, a_v, b_spike, b_v);
        end
        $display("test_saturation done");
    endtask

    task automatic test_threshold_zero();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, $urandom_range(255), 0);
            checks++;
            if (b_spike !== 1'b1 || b_cnt !== 16'(n + 1) || a_spike !== m_spike[0]) begin
                errors++; $display("FAIL thr_zero[%0d]: got b_spike=%0b b_cnt=%0d a_spike=%0b, want 1 %0d %0b", n, b_spike, b_cnt, a_spike, n + 1, m_spike[0]);
            end
        end
        $display("test_threshold_zero done");
    endtask

    task automatic test_random();
        int i, t;
        bit e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(9) < 8);
            i = $urandom_range(255);
            t = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(40, 160);
            cycle(e, i, t);
            checks++;
            if (a_v !== 8'(m_v[0]) || a_spike !== m_spike[0] || a_refr !== m_refr[0] || a_cnt !== 16'(m_cnt[0])) begin
                errors++; $display("FAIL random_a[%0d]: got v=%0d spike=%0b refr=%0b cnt=%0d, want v=%0d spike=%0b refr=%0b cnt=%0d",
                                   n, a_v, a_spike, a_refr, a_cnt, m_v[0], m_spike[0], m_refr[0], m_cnt[0]);
            end
            checks++;
            if (b_v !== 8'(m_v[1]) || b_spike !== m_spike[1] || b_refr !== m_refr[1] || b_cnt !== 16'(m_cnt[1])) begin
                errors++; $display("FAIL random_b[%0d]: got v=%0d spike=%0b refr=%0b cnt=%0d, want v=%0d spike=%0b refr=%0b cnt=%0d",
                                   n, b_v, b_spike, b_refr, b_cnt, m_v[1], m_spike[1], m_refr[1], m_cnt[1]);
            end
        end
        $display("test_random done: a spikes=%0d b spikes=%0d", m_cnt[0], m_cnt[1]);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_integrate_fire();
        test_refractory();
        test_enable_hold();
        test_reset_mid_refractory();
        test_saturation();
        test_threshold_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_neuron_param.md
LIF_NEURON_PARAM -- requirements
Module: lif_neuron_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: membrane, current and threshold width.
REQ-002 SHALL have parameter CUR_SHIFT, default 1: input scaling, added term = synaptic_current >> CUR_SHIFT.
REQ-003 SHALL have parameter LEAK_SHIFT, default 3: leak term = V >> LEAK_SHIFT.
REQ-004 SHALL have parameter REFRACT_CYCLES, default 4: enabled cycles spent refractory after a spike; 0 = no refractory.
REQ-005 SHALL have parameter RESET_MODE, default 0: post-spike V (0 = zero, 1 = subtract threshold).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port en  input  1  time-step enable; when 0, all state holds.
REQ-009 SHALL have port synaptic_current  input  WIDTH  unsigned input current.
REQ-010 SHALL have port threshold  input  WIDTH  unsigned firing threshold, sampled every enabled cycle.
REQ-011 SHALL have port spike  output  1  registered one-cycle spike pulse.
REQ-012 SHALL have port membrane_potential  output  WIDTH  registered V.
REQ-013 SHALL have port refractory  output  1  high while in REFRACTORY state.
REQ-014 SHALL have port spike_count  output  16  total spikes since reset, wraps 0xFFFF->0.

Function
REQ-015 SHALL implement two states: INTEGRATE, REFRACTORY.
REQ-016 In INTEGRATE with en=1: sum = (V - (V>>LEAK_SHIFT)) + (synaptic_current>>CUR_SHIFT), computed at WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-017 If sum >= threshold: next cycle spike=1, V = 0 (RESET_MODE 0) or sum-threshold (RESET_MODE 1), spike_count+1, state -> REFRACTORY with counter = REFRACT_CYCLES (stay INTEGRATE if REFRACT_CYCLES=0).
REQ-018 Otherwise V <= sum, spike=0.
REQ-019 spike SHALL be high exactly one cycle per firing; never high in two consecutive cycles unless REFRACT_CYCLES=0 and threshold is crossed again.
REQ-020 In REFRACTORY with en=1: V held, input ignored, no leak, counter decrements; at counter==1 state -> INTEGRATE next cycle.
REQ-021 en=0: V, state, counter, spike_count hold; spike driven 0.
REQ-022 threshold=0: fires on every enabled INTEGRATE cycle.
REQ-023 Latency: input to V/spike update exactly one clock.

Reset
REQ-024 rst_n low SHALL asynchronously force V=0, spike=0, refractory=0, spike_count=0, counter=0, state=INTEGRATE, including mid-refractory.
REQ-025 First update SHALL occur on the first enabled rising edge after rst_n deasserts.

Structure
REQ-026 State encoding and default parameter constants SHALL live in shared package lif_pkg.
REQ-027 Saturating leak-integrate datapath SHALL be sub-module lif_sat_integrate (combinational, WIDTH-parametrised); FSM, counters, registers in top.

Verification (defaults, threshold=100 unless stated)
REQ-028 Constant I=40, en=1 -> V sequence 20,38,54,68,80,90,99, then spike=1 with V=0, spike_count=1.
REQ-029 After REQ-028 spike -> refractory=1 for 4 enabled cycles, V=0 despite I=40, then integration resumes at 20.
REQ-030 RESET_MODE=1, same stimulus -> spike with V=7 (107-100).
REQ-031 I=255, threshold=255 -> V 127, 239, then saturated sum 255 fires spike; V never exceeds 255.
REQ-032 en toggled 0 for 3 cycles mid-integration (V=54) -> V stays 54, no spike, counter frozen; rst_n pulsed low during refractory -> all outputs 0 immediately, state INTEGRATE.
